// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the programmable clock/tick divider bank.
package clk_div_pkg;

  // Output shaping: TOGGLE gives a 50 % square wave, PULSE mirrors the tick.
  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  localparam int unsigned DEFAULT_CNT_W = 16;
  localparam logic [DEFAULT_CNT_W-1:0] DEFAULT_DIV_VAL = 16'h3333;

  // Width of a channel-select field for n channels, never below one bit.
  function automatic int unsigned ch_w(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow divisor and mode, pending update.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned      CNT_W   = DEFAULT_CNT_W,
  parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV_VAL)
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  input  mode_e            load_mode,
  output logic             tick,
  output logic             clk_out,
  output logic             pending
);

  logic [CNT_W-1:0] q;
  logic [CNT_W-1:0] div_act;
  logic [CNT_W-1:0] div_shd;
  mode_e            mode_act;
  mode_e            mode_shd;

  logic  tc_c;
  logic  apply_c;
  mode_e mode_nxt_c;

  // Terminal count; a shadow update lands on that edge or on any disabled cycle,
  // so the divisor only ever changes while q is 0.
  assign tc_c       = en && (q == div_act);
  assign apply_c    = pending && (tc_c || !en);
  assign mode_nxt_c = apply_c ? mode_shd : mode_act;

  // Counter and one-cycle tick strobe.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      q    <= '0;
      tick <= 1'b0;
    end else if (!en) begin
      q    <= '0;
      tick <= 1'b0;
    end else if (tc_c) begin
      q    <= '0;
      tick <= 1'b1;
    end else begin
      q    <= q + CNT_W'(1);
      tick <= 1'b0;
    end
  end

  // Divided output; the mode taking effect on this edge decides the shaping.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      clk_out <= 1'b0;
    end else if (mode_nxt_c == MODE_PULSE) begin
      clk_out <= tc_c;
    end else if (apply_c && (mode_act == MODE_PULSE)) begin
      clk_out <= 1'b0;
    end else if (tc_c) begin
      clk_out <= ~clk_out;
    end
  end

  // Active/shadow configuration and the pending flag.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      div_act  <= DIV_RST;
      mode_act <= MODE_TOGGLE;
      div_shd  <= DIV_RST;
      mode_shd <= MODE_TOGGLE;
      pending  <= 1'b0;
    end else begin
      if (apply_c) begin
        div_act  <= div_shd;
        mode_act <= mode_shd;
      end
      if (load) begin
        div_shd  <= load_div;
        mode_shd <= load_mode;
      end
      // A load is only offered while pending is clear, so it never races an apply.
      if (load) begin
        pending <= 1'b1;
      end else if (apply_c) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent programmable tick/clock dividers sharing one config port.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned      NCH         = 4,
  parameter int unsigned      CNT_W       = DEFAULT_CNT_W,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEFAULT_DIV_VAL),
  localparam int unsigned     CH_W        = ch_w(NCH)
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic [NCH-1:0]   en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_mode,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   clk_out
);

  logic [NCH-1:0] pending;
  logic [NCH-1:0] load;
  logic [31:0]    ch_idx;

  assign ch_idx = 32'(cfg_ch);

  // Ready mirrors the addressed channel's pending flag; unknown channels always accept.
  always_comb begin
    cfg_ready = 1'b1;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (ch_idx == i) begin
        cfg_ready = ~pending[i];
      end
    end
  end

  // Decode an accepted request into a single per-channel load strobe.
  always_comb begin
    load = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      load[i] = cfg_valid && cfg_ready && (ch_idx == i);
    end
  end

  // One divider per channel.
  for (genvar g = 0; g < NCH; g++) begin : g_chan
    clk_div_chan #(
      .CNT_W   (CNT_W),
      .DIV_RST (DEFAULT_DIV)
    ) u_chan (
      .clk       (clk),
      .rst_l     (rst_l),
      .en        (en[g]),
      .load      (load[g]),
      .load_div  (cfg_div),
      .load_mode (mode_e'(cfg_mode)),
      .tick      (tick[g]),
      .clk_out   (clk_out[g]),
      .pending   (pending[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: stimulus queues expectations, a monitor retires them.
module tb_clk_div_bank;

  localparam int NCH = 4;

  logic        clk;
  logic        rst_l;
  logic [3:0]  en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic        cfg_mode;
  logic [3:0]  tick;
  logic [3:0]  clk_out;

  clk_div_bank dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_mode  (cfg_mode),
    .tick      (tick),
    .clk_out   (clk_out)
  );

  typedef enum int {K_TICK, K_OUT, K_RDY, K_IDLE} kind_e;
  typedef struct {
    kind_e kind;
    int    cyc;
    int    ch;
    logic  a;
    logic  b;
    string name;
  } exp_t;

  exp_t sb[$];
  exp_t keep[$];
  exp_t e;
  logic [3:0] seen;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int t;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Expected tick on channel ch at cycle c, with clk_out level co on that cycle.
  function automatic void exp_tick(input int ch, input int c, input logic co, input string nm);
    exp_t x;
    x.kind = K_TICK; x.cyc = c; x.ch = ch; x.a = co; x.b = 1'b0; x.name = nm;
    sb.push_back(x);
  endfunction

  function automatic void exp_out(input int ch, input int c, input logic tk, input logic co, input string nm);
    exp_t x;
    x.kind = K_OUT; x.cyc = c; x.ch = ch; x.a = tk; x.b = co; x.name = nm;
    sb.push_back(x);
  endfunction

  function automatic void exp_rdy(input int c, input logic r, input string nm);
    exp_t x;
    x.kind = K_RDY; x.cyc = c; x.ch = 0; x.a = r; x.b = 1'b0; x.name = nm;
    sb.push_back(x);
  endfunction

  function automatic void exp_idle(input int c, input string nm);
    exp_t x;
    x.kind = K_IDLE; x.cyc = c; x.ch = 0; x.a = 1'b0; x.b = 1'b0; x.name = nm;
    sb.push_back(x);
  endfunction

  // Monitor: retire expectations at the falling edge, away from DUT updates.
  always @(negedge clk) begin
    keep = {};
    seen = '0;
    foreach (sb[i]) begin
      e = sb[i];
      if (e.kind == K_TICK && !seen[e.ch] && tick[e.ch]) begin
        seen[e.ch] = 1'b1;
        checks++;
        if (e.cyc != cyc || clk_out[e.ch] !== e.a) begin
          errors++;
          $display("FAIL %s ch%0d: tick at cycle %0d clk_out=%0b, expected cycle %0d clk_out=%0b",
                   e.name, e.ch, cyc, clk_out[e.ch], e.cyc, e.a);
        end
      end else if (e.kind != K_TICK && e.cyc == cyc) begin
        checks++;
        case (e.kind)
          K_OUT: if (tick[e.ch] !== e.a || clk_out[e.ch] !== e.b) begin
            errors++;
            $display("FAIL %s ch%0d cycle %0d: tick=%0b clk_out=%0b, expected tick=%0b clk_out=%0b",
                     e.name, e.ch, cyc, tick[e.ch], clk_out[e.ch], e.a, e.b);
          end
          K_RDY: if (cfg_ready !== e.a) begin
            errors++;
            $display("FAIL %s cycle %0d: cfg_ready=%0b, expected %0b", e.name, cyc, cfg_ready, e.a);
          end
          default: if (tick !== 4'b0000 || clk_out !== 4'b0000 || cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s cycle %0d: tick=%b clk_out=%b cfg_ready=%0b, expected 0000 0000 1",
                     e.name, cyc, tick, clk_out, cfg_ready);
          end
        endcase
      end else if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s ch%0d: expected event at cycle %0d never observed (now %0d)",
                 e.name, e.ch, e.cyc, cyc);
      end else begin
        keep.push_back(e);
      end
    end
    sb = keep;
    for (int c = 0; c < NCH; c++) begin
      if (tick[c] && !seen[c]) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tick ch%0d cycle %0d: tick=1, expected 0", c, cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  // Issue one config request that must be accepted on the next edge.
  task automatic cfg(input int ch, input int dv, input logic md);
    cfg_ch    = 2'(ch);
    cfg_div   = 16'(dv);
    cfg_mode  = md;
    cfg_valid = 1'b1;
    exp_rdy(cyc, 1'b1, "cfg_accept_ready");
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst_l = 1'b0; en = 4'b0000; cfg_valid = 1'b0;
    cfg_ch = 2'd0; cfg_div = 16'd0; cfg_mode = 1'b0;
    step();
    exp_idle(cyc, "reset_state");
    step(); step();
    rst_l = 1'b1;
    step();

    // Default divisor on ch0: tick every 13108 cycles, clk_out period 26216.
    t = cyc;
    en = 4'b0001;
    exp_tick(0, t + 13108, 1'b1, "default_tick1");
    exp_tick(0, t + 26216, 1'b0, "default_tick2");
    for (int c = 1; c < NCH; c++) begin
      exp_out(c, t + 100,   1'b0, 1'b0, "idle_channel");
      exp_out(c, t + 20000, 1'b0, 1'b0, "idle_channel_late");
    end
    wait_until(t + 26216);
    en[0] = 1'b0;
    exp_out(0, cyc + 3, 1'b0, 1'b0, "ch0_disabled_hold");
    step(); step(); step(); step();

    // ch1 div 3 configured while disabled, then enabled.
    cfg(1, 3, 1'b0);
    step();
    t = cyc;
    en[1] = 1'b1;
    for (int k = 1; k <= 4; k++) exp_tick(1, t + 4 * k, logic'(k % 2), "ch1_div3");
    wait_until(t + 16);
    en[1] = 1'b0;
    exp_out(1, cyc + 2, 1'b0, 1'b0, "ch1_disabled_hold");
    step(); step(); step();

    // ch2 div 9, mid-period rewrite to 2, then a second write blocked until apply.
    cfg(2, 9, 1'b0);
    step();
    t = cyc;
    en[2] = 1'b1;
    exp_tick(2, t + 10, 1'b1, "ch2_div9_a");
    exp_tick(2, t + 20, 1'b0, "ch2_div9_b");
    exp_tick(2, t + 23, 1'b1, "ch2_div2");
    exp_tick(2, t + 29, 1'b0, "ch2_div5_a");
    exp_tick(2, t + 35, 1'b1, "ch2_div5_b");
    wait_until(t + 13);
    cfg_ch = 2'd2; cfg_div = 16'd2; cfg_mode = 1'b0; cfg_valid = 1'b1;
    exp_rdy(cyc, 1'b1, "ch2_first_write_ready");
    step();
    cfg_div = 16'd5;
    for (int c = t + 14; c <= t + 19; c++) exp_rdy(c, 1'b0, "ch2_blocked_ready");
    exp_rdy(t + 20, 1'b1, "ch2_ready_at_apply");
    wait_until(t + 20);
    step();
    cfg_valid = 1'b0;
    wait_until(t + 35);
    en[2] = 1'b0;
    exp_out(2, cyc + 2, 1'b0, 1'b1, "ch2_disabled_hold_high");
    step(); step(); step();

    // ch3 div 0 PULSE: tick and clk_out high every enabled cycle.
    cfg(3, 0, 1'b1);
    step();
    t = cyc;
    en[3] = 1'b1;
    for (int k = 1; k <= 6; k++) exp_tick(3, t + k, 1'b1, "ch3_div0_pulse");
    wait_until(t + 6);
    en[3] = 1'b0;
    exp_out(3, t + 7, 1'b0, 1'b0, "ch3_drop_en");
    step(); step(); step();

    // ch0 div 4, write div 1 on the same edge as a terminal count.
    cfg(0, 4, 1'b0);
    step();
    t = cyc;
    en[0] = 1'b1;
    exp_tick(0, t + 5,  1'b1, "ch0_div4_a");
    exp_tick(0, t + 10, 1'b0, "ch0_div4_b");
    exp_tick(0, t + 15, 1'b1, "ch0_div4_c");
    exp_tick(0, t + 17, 1'b0, "ch0_div1_a");
    exp_tick(0, t + 19, 1'b1, "ch0_div1_b");
    wait_until(t + 9);
    cfg_ch = 2'd0; cfg_div = 16'd1; cfg_mode = 1'b0; cfg_valid = 1'b1;
    exp_rdy(cyc, 1'b1, "ch0_coincident_ready");
    step();
    cfg_valid = 1'b0;
    exp_rdy(t + 10, 1'b0, "ch0_pending_after_tc");
    exp_rdy(t + 14, 1'b0, "ch0_pending_before_apply");
    exp_rdy(t + 15, 1'b1, "ch0_ready_after_apply");
    wait_until(t + 19);
    en[0] = 1'b0;
    step(); step(); step();

    // Async reset mid-count with a pending update on ch1 (ch2 clk_out is high).
    en = 4'b0010;
    cfg(1, 7, 1'b0);
    rst_l = 1'b0;
    exp_idle(cyc, "async_reset");
    en = 4'b0000;
    step(); step();
    rst_l = 1'b1;
    step();
    t = cyc;
    en[1] = 1'b1;
    exp_tick(1, t + 13108, 1'b1, "post_reset_default_div");
    wait_until(t + 13110);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
